// File: rtl/fcims_pkg.sv
// Shared encodings for the food-court inventory ledger: opcodes, response status, FSM states.
package fcims_pkg;

  typedef enum logic [1:0] {
    OP_SELL      = 2'b00,
    OP_RESTOCK   = 2'b01,
    OP_SET_PRICE = 2'b10,
    OP_QUERY     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    STAT_OK       = 2'b00,
    STAT_NO_STOCK = 2'b01,
    STAT_OVERFLOW = 2'b10,
    STAT_BAD_ITEM = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/fcims_item_bank.sv
// Per-item price and stock registers: one combinational read port, one write port, low-stock flags.
module fcims_item_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int ITEM_W     = 2,
  parameter int PRICE_W    = 4,
  parameter int STOCK_W    = 4,
  parameter int LOW_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ITEM_W-1:0]    rd_idx,
  output logic [PRICE_W-1:0]   rd_price,
  output logic [STOCK_W-1:0]   rd_stock,
  input  logic [ITEM_W-1:0]    wr_idx,
  input  logic                 wr_price_en,
  input  logic [PRICE_W-1:0]   wr_price,
  input  logic                 wr_stock_en,
  input  logic [STOCK_W-1:0]   wr_stock,
  output logic [NUM_ITEMS-1:0] low_stock
);

  logic [PRICE_W-1:0] price_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

  logic rd_ok, wr_ok;
  assign rd_ok = 32'(rd_idx) < NUM_ITEMS;
  assign wr_ok = 32'(wr_idx) < NUM_ITEMS;

  always_comb begin
    rd_price = '0;
    rd_stock = '0;
    if (rd_ok) begin
      rd_price = price_q[rd_idx];
      rd_stock = stock_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        price_q[i] <= '0;
        stock_q[i] <= '0;
      end
    end else begin
      if (wr_price_en && wr_ok) price_q[wr_idx] <= wr_price;
      if (wr_stock_en && wr_ok) stock_q[wr_idx] <= wr_stock;
    end
  end

  always_comb begin
    low_stock = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++)
      low_stock[i] = stock_q[i] <= STOCK_W'(LOW_THRESH);
  end

endmodule

// File: rtl/fcims_ledger.sv
// Sequential inventory/price ledger: one transaction at a time over valid/ready, saturating revenue.
module fcims_ledger
  import fcims_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int PRICE_W    = 4,
  parameter int QTY_W      = 4,
  parameter int STOCK_W    = 4,
  parameter int REV_W      = 16,
  parameter int LOW_THRESH = 1,
  localparam int ITEM_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [ITEM_W-1:0]          req_item,
  input  logic [QTY_W-1:0]           req_qty,
  input  logic [PRICE_W-1:0]         req_price,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [1:0]                 rsp_status,
  output logic [PRICE_W+QTY_W-1:0]   rsp_total,
  output logic [STOCK_W-1:0]         rsp_stock,
  output logic [REV_W-1:0]           revenue,
  output logic [NUM_ITEMS-1:0]       low_stock
);

  localparam int TOT_W = PRICE_W + QTY_W;
  localparam int SUM_W = ((STOCK_W > QTY_W) ? STOCK_W : QTY_W) + 1;
  localparam int RS_W  = ((REV_W > TOT_W) ? REV_W : TOT_W) + 1;
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
  localparam logic [REV_W-1:0]   REV_MAX   = '1;

  state_e              state;
  op_e                 op_q;
  logic [ITEM_W-1:0]   item_q;
  logic [QTY_W-1:0]    qty_q;
  logic [PRICE_W-1:0]  price_q;

  logic [PRICE_W-1:0]  rd_price;
  logic [STOCK_W-1:0]  rd_stock;
  logic                price_we, stock_we, price_we_raw, stock_we_raw;
  logic [STOCK_W-1:0]  wr_stock;

  status_e             nxt_status;
  logic [TOT_W-1:0]    nxt_total;
  logic [STOCK_W-1:0]  nxt_stock;
  logic [REV_W-1:0]    nxt_rev;
  logic [TOT_W-1:0]    product;
  logic [SUM_W-1:0]    restock_sum;
  logic [RS_W-1:0]     rev_sum;
  logic                bad;

  fcims_item_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .ITEM_W    (ITEM_W),
    .PRICE_W   (PRICE_W),
    .STOCK_W   (STOCK_W),
    .LOW_THRESH(LOW_THRESH)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (item_q),
    .rd_price   (rd_price),
    .rd_stock   (rd_stock),
    .wr_idx     (item_q),
    .wr_price_en(price_we),
    .wr_price   (price_q),
    .wr_stock_en(stock_we),
    .wr_stock   (wr_stock),
    .low_stock  (low_stock)
  );

  assign bad         = 32'(item_q) >= NUM_ITEMS;
  assign product     = TOT_W'(rd_price) * TOT_W'(qty_q);
  assign restock_sum = SUM_W'(rd_stock) + SUM_W'(qty_q);
  assign rev_sum     = RS_W'(revenue) + RS_W'(product);

  always_comb begin
    nxt_status   = STAT_OK;
    nxt_total    = '0;
    nxt_stock    = rd_stock;
    nxt_rev      = revenue;
    wr_stock     = rd_stock;
    price_we_raw = 1'b0;
    stock_we_raw = 1'b0;
    if (bad) begin
      nxt_status = STAT_BAD_ITEM;
      nxt_stock  = '0;
    end else begin
      case (op_q)
        OP_SELL: begin
          if (SUM_W'(qty_q) > SUM_W'(rd_stock)) begin
            nxt_status = STAT_NO_STOCK;
          end else begin
            wr_stock     = rd_stock - STOCK_W'(qty_q);
            nxt_stock    = wr_stock;
            stock_we_raw = 1'b1;
            nxt_total    = product;
            nxt_rev      = (rev_sum > RS_W'(REV_MAX)) ? REV_MAX : rev_sum[REV_W-1:0];
          end
        end
        OP_RESTOCK: begin
          if (restock_sum > SUM_W'(STOCK_MAX)) begin
            nxt_status = STAT_OVERFLOW;
          end else begin
            wr_stock     = restock_sum[STOCK_W-1:0];
            nxt_stock    = wr_stock;
            stock_we_raw = 1'b1;
          end
        end
        OP_SET_PRICE: price_we_raw = 1'b1;
        default:      nxt_total = TOT_W'(rd_price);
      endcase
    end
  end

  assign price_we = price_we_raw && (state == S_EXEC);
  assign stock_we = stock_we_raw && (state == S_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_total  <= '0;
      rsp_stock  <= '0;
      revenue    <= '0;
      op_q       <= OP_SELL;
      item_q     <= '0;
      qty_q      <= '0;
      price_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q      <= op_e'(req_op);
          item_q    <= req_item;
          qty_q     <= req_qty;
          price_q   <= req_price;
          req_ready <= 1'b0;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          rsp_status <= nxt_status;
          rsp_total  <= nxt_total;
          rsp_stock  <= nxt_stock;
          revenue    <= nxt_rev;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcims_ledger.sv
// Directed bench for fcims_ledger built with 3 items and an 8-bit revenue register.
module tb_fcims_ledger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [1:0] req_item;
  logic [3:0] req_qty, req_price;
  logic       rsp_valid, rsp_ready;
  logic [1:0] rsp_status;
  logic [7:0] rsp_total;
  logic [3:0] rsp_stock;
  logic [7:0] revenue;
  logic [2:0] low_stock;

  int checks = 0;
  int errors = 0;
  logic [1:0] r_status;
  logic [7:0] r_total;
  logic [3:0] r_stock;

  always #5 clk = ~clk;

  fcims_ledger #(.NUM_ITEMS(3), .REV_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_item  (req_item),
    .req_qty   (req_qty),
    .req_price (req_price),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_status(rsp_status),
    .rsp_total (rsp_total),
    .rsp_stock (rsp_stock),
    .revenue   (revenue),
    .low_stock (low_stock)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check(tag, {rsp_valid, req_ready, rsp_status, rsp_total, rsp_stock, revenue, low_stock},
          {1'b0, 1'b1, 2'b00, 8'd0, 4'd0, 8'd0, 3'b111});
  endtask

  task automatic txn(input logic [1:0] op, input logic [1:0] item,
                     input logic [3:0] qty, input logic [3:0] price);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_item = item; req_qty = qty; req_price = price;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_bound", 32'(n < 20), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rsp_not_early", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    check("rsp_latency", 32'(rsp_valid), 1);
    r_status = rsp_status; r_total = rsp_total; r_stock = rsp_stock;
    @(posedge clk); #1;
    check("back_idle", {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic expect_rsp(input string tag, input logic [1:0] st,
                            input logic [7:0] tot, input logic [3:0] stk);
    check(tag, {r_status, r_total, r_stock}, {st, tot, stk});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_item = '0;
    req_qty = '0; req_price = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst_n = 1'b1;

    txn(2'b10, 2'd1, 4'd0, 4'd9);
    expect_rsp("set_price_1", 2'b00, 8'd0, 4'd0);
    txn(2'b01, 2'd1, 4'd12, 4'd0);
    expect_rsp("restock_12", 2'b00, 8'd0, 4'd12);
    check("low_stock_after_restock", 32'(low_stock), 3'b101);

    txn(2'b00, 2'd1, 4'd3, 4'd0);
    expect_rsp("sell_3", 2'b00, 8'd27, 4'd9);
    check("revenue_27", 32'(revenue), 27);
    txn(2'b11, 2'd1, 4'd0, 4'd0);
    expect_rsp("query_1", 2'b00, 8'd9, 4'd9);

    txn(2'b00, 2'd1, 4'd10, 4'd0);
    expect_rsp("sell_no_stock", 2'b01, 8'd0, 4'd9);
    check("revenue_kept", 32'(revenue), 27);
    txn(2'b01, 2'd1, 4'd7, 4'd0);
    expect_rsp("restock_overflow", 2'b10, 8'd0, 4'd9);
    txn(2'b01, 2'd1, 4'd6, 4'd0);
    expect_rsp("restock_to_max", 2'b00, 8'd0, 4'd15);
    txn(2'b00, 2'd1, 4'd0, 4'd0);
    expect_rsp("sell_qty0", 2'b00, 8'd0, 4'd15);

    // Backpressure: response held while a second request waits
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_item = 2'd1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_op = 2'b01; req_item = 2'd0; req_qty = 4'd1;
    @(posedge clk); #1;
    check("bp_first_rsp", {rsp_valid, rsp_status, rsp_total, rsp_stock}, {1'b1, 2'b00, 8'd9, 4'd15});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {rsp_valid, req_ready, rsp_status, rsp_total, rsp_stock},
            {1'b1, 1'b0, 2'b00, 8'd9, 4'd15});
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", {rsp_valid, req_ready}, 2'b01);
    @(posedge clk); #1;
    check("bp_second_accepted", 32'(req_ready), 0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_second_rsp", {rsp_valid, rsp_status, rsp_total, rsp_stock}, {1'b1, 2'b00, 8'd0, 4'd1});
    @(posedge clk); #1;
    check("low_stock_at_thresh", 32'(low_stock), 3'b101);
    txn(2'b01, 2'd0, 4'd1, 4'd0);
    expect_rsp("restock_item0", 2'b00, 8'd0, 4'd2);
    check("low_stock_above_thresh", 32'(low_stock), 3'b100);

    txn(2'b00, 2'd3, 4'd1, 4'd0);
    expect_rsp("bad_item_sell", 2'b11, 8'd0, 4'd0);
    txn(2'b10, 2'd3, 4'd0, 4'd7);
    expect_rsp("bad_item_setprice", 2'b11, 8'd0, 4'd0);
    check("bad_item_no_change", {revenue, low_stock}, {8'd27, 3'b100});

    txn(2'b10, 2'd2, 4'd0, 4'd15);
    txn(2'b01, 2'd2, 4'd15, 4'd0);
    txn(2'b00, 2'd2, 4'd15, 4'd0);
    expect_rsp("sell_225", 2'b00, 8'd225, 4'd0);
    check("revenue_252", 32'(revenue), 252);
    txn(2'b01, 2'd2, 4'd15, 4'd0);
    txn(2'b00, 2'd2, 4'd15, 4'd0);
    expect_rsp("sell_225_sat", 2'b00, 8'd225, 4'd0);
    check("revenue_saturated", 32'(revenue), 255);

    // Reset while in EXEC
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_item = 2'd1; req_qty = 4'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset("reset_in_exec");
    @(negedge clk); rst_n = 1'b1;
    txn(2'b11, 2'd1, 4'd0, 4'd0);
    expect_rsp("after_exec_reset", 2'b00, 8'd0, 4'd0);

    // Reset while in RESP
    txn(2'b10, 2'd0, 4'd0, 4'd5);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_item = 2'd0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("resp_before_reset", {rsp_valid, rsp_total}, {1'b1, 8'd5});
    rst_n = 1'b0;
    #1 check_reset("reset_in_resp");
    @(negedge clk); rst_n = 1'b1;
    txn(2'b11, 2'd0, 4'd0, 4'd0);
    expect_rsp("after_resp_reset", 2'b00, 8'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
